exc_ctrl: RTL

Exception/interrupt sequencer directly upstream of the CP0 register file.
- Takes decoded trap events (syscall, break, teq-taken, eret) from the decode stage, plus raw external interrupt lines.
- Arbitrates them against the CP0 status word.
- Drives CP0's exception/eret/cause/pc inputs with a fixed multi-cycle sequence, stalling fetch and redirecting the PC to the handler or to EPC.

---
 rtl/exc_pkg.sv | 23 ++
 rtl/irq_sync_edge.sv | 29 ++
 rtl/exc_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: cause codes, status bit
// positions and the sequencer state encoding.
package exc_pkg;

  localparam logic [4:0] CAUSE_INT = 5'd0;
  localparam logic [4:0] CAUSE_SYS = 5'd8;
  localparam logic [4:0] CAUSE_BRK = 5'd9;
  localparam logic [4:0] CAUSE_TEQ = 5'd13;

  localparam int ST_IE     = 0;
  localparam int ST_SYS_EN = 1;
  localparam int ST_BRK_EN = 2;
  localparam int ST_TEQ_EN = 3;
  localparam int ST_IM_LSB = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTER = 2'd1,
    S_JUMP  = 2'd2,
    S_RET   = 2'd3
  } state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser per interrupt line followed by a rising-edge detector
// on the synchronised level.
module irq_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1_p0, s2_p1, s3_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_p0 <= '0;
      s2_p1 <= '0;
      s3_p2 <= '0;
    end else begin
      s1_p0 <= d;
      s2_p1 <= s1_p0;
      s3_p2 <= s2_p1;
    end
  end

  // s3_p2 is the previous synchronised level, used only for edge detection
  assign rise = s2_p1 & ~s3_p2;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer feeding CP0: arbitrates traps and interrupts,
// then runs a fixed ENTER/JUMP or RET sequence that stalls and redirects fetch.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0040_0004,
  parameter int          NIRQ       = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     pc,
  input  logic            is_syscall,
  input  logic            is_break,
  input  logic            is_teq_taken,
  input  logic            is_eret,
  input  logic [NIRQ-1:0] irq,
  input  logic [31:0]     status,
  input  logic [31:0]     epc_in,
  output logic            exception,
  output logic            eret,
  output logic [4:0]      cause,
  output logic [31:0]     epc,
  output logic            stall,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic [NIRQ-1:0] irq_pending
);

  state_t          state_q, state_nxt;
  logic [NIRQ-1:0] irq_rise, pending_q, masked, int_clr;
  logic            int_ok, sys_ok, brk_ok, teq_ok;
  logic            take_exc, take_ret, take_int;
  logic [4:0]      cause_nxt, cause_q;
  logic [31:0]     epc_q;

  irq_sync_edge #(.W(NIRQ)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (irq),
    .rise (irq_rise)
  );

  assign masked = pending_q & status[ST_IM_LSB +: NIRQ];
  assign int_ok = status[ST_IE] & (|masked);
  assign sys_ok = status[ST_IE] & status[ST_SYS_EN] & is_syscall;
  assign brk_ok = status[ST_IE] & status[ST_BRK_EN] & is_break;
  assign teq_ok = status[ST_IE] & status[ST_TEQ_EN] & is_teq_taken;

  // Arbitration: one event per cycle, only when idle with a valid instruction
  always_comb begin
    take_exc  = 1'b0;
    take_ret  = 1'b0;
    take_int  = 1'b0;
    cause_nxt = CAUSE_INT;
    if (state_q == S_IDLE && instr_valid) begin
      if (int_ok) begin
        take_exc = 1'b1;
        take_int = 1'b1;
      end else if (sys_ok) begin
        take_exc  = 1'b1;
        cause_nxt = CAUSE_SYS;
      end else if (brk_ok) begin
        take_exc  = 1'b1;
        cause_nxt = CAUSE_BRK;
      end else if (teq_ok) begin
        take_exc  = 1'b1;
        cause_nxt = CAUSE_TEQ;
      end else if (is_eret) begin
        take_ret = 1'b1;
      end
    end
  end

  // Only the lowest masked pending bit is retired; a fresh edge on it still wins
  assign int_clr = take_int ? (masked & (~masked + NIRQ'(1))) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cause_q   <= '0;
      epc_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~int_clr) | irq_rise;
      if (take_exc) begin
        cause_q <= cause_nxt;
        epc_q   <= pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_exc)      state_nxt = S_ENTER;
        else if (take_ret) state_nxt = S_RET;
      end
      S_ENTER: state_nxt = S_JUMP;
      S_JUMP:  state_nxt = S_IDLE;
      S_RET:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    exception   = 1'b0;
    eret        = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state_q)
      S_ENTER: begin
        exception = 1'b1;
        stall     = 1'b1;
      end
      S_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = HANDLER_PC;
        stall       = 1'b1;
      end
      // CP0 drives EPC combinationally while eret is high
      S_RET: begin
        eret        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = epc_in;
        stall       = 1'b1;
      end
      default: ;
    endcase
  end

  assign cause       = cause_q;
  assign epc         = epc_q;
  assign irq_pending = pending_q;

endmodule
